apb_reg_bank: RTL and testbench

APB_REG_BANK -- requirements
Module: apb_reg_bank

---
 rtl/apb_reg_pkg.sv | 37 +++
 rtl/apb_wait_ctr.sv | 28 ++
 rtl/apb_reg_bank.sv | 161 ++++++++++++++++
 tb/tb_apb_reg_bank.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_reg_pkg.sv
// Shared definitions for the APB register bank:
// register offsets, ID tag, handshake state encoding.
package apb_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [4:0] OFF_ID      = 5'h00;
  localparam logic [4:0] OFF_CTRL    = 5'h04;
  localparam logic [4:0] OFF_STATUS  = 5'h08;
  localparam logic [4:0] OFF_IRQ_EN  = 5'h0C;
  localparam logic [4:0] OFF_SCRATCH = 5'h10;
  localparam logic [4:0] OFF_CNT     = 5'h14;

  localparam logic [15:0] ID_TAG = 16'hA5B0;

  function automatic logic [31:0] lane_mask(
    input logic [3:0] s
  );
    return {{8{s[3]}}, {8{s[2]}},
            {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  s
  );
    logic [31:0] m;
    m = lane_mask(s);
    return (old & ~m) | (nw & m);
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter for APB wait states;
// done is high whenever the count sits at zero.
module apb_wait_ctr #(
  parameter int W = 4
) (
  input  logic         pclk,
  input  logic         prst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/apb_reg_bank.sv
// APB register bank: ID/CTRL/STATUS/IRQ_EN/SCRATCH/CNT
// behind an IDLE/BUSY/DONE wait-state handshake.
module apb_reg_bank
  import apb_reg_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  pclk,
  input  logic                  prst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [3:0]            b_strobe,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            ecorevnum,
  input  logic                  hw_event,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  pready_r,
  output logic                  pslverr_r,
  output logic [DATA_WIDTH-1:0] ctrl_out,
  output logic                  irq
);

  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] LOAD_V =
    NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e state_q, state_d;

  logic        req;
  logic        ctr_done;
  logic        ctr_load;
  logic        commit;
  logic        hi_zero;
  logic        sel_id, sel_ctrl, sel_status;
  logic        sel_ien, sel_scr, sel_cnt;
  logic        mapped;
  logic        err;
  logic        wr_ok;
  logic [31:0] rd_val;
  logic [31:0] clr;

  logic [31:0] ctrl_q;
  logic [31:0] status_q;
  logic [31:0] irq_en_q;
  logic [31:0] scratch_q;
  logic [31:0] cnt_q;

  assign req      = rd | wr;
  assign ctr_load = (state_q == ST_IDLE) && req && !NO_WAIT;

  apb_wait_ctr #(.W(4)) u_wait_ctr (
    .pclk     (pclk),
    .prst_n   (prst_n),
    .load     (ctr_load),
    .load_val (LOAD_V),
    .dec      (state_q == ST_BUSY),
    .done     (ctr_done)
  );

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = NO_WAIT ? ST_DONE : ST_BUSY;
          commit  = NO_WAIT;
        end
      end
      ST_BUSY: begin
        if (ctr_done) begin
          state_d = ST_DONE;
          commit  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Anything outside the low 32 bytes is unmapped.
  assign hi_zero    = ((addr >> 5) == '0);
  assign sel_id     = hi_zero && addr[4:0] == OFF_ID;
  assign sel_ctrl   = hi_zero && addr[4:0] == OFF_CTRL;
  assign sel_status = hi_zero && addr[4:0] == OFF_STATUS;
  assign sel_ien    = hi_zero && addr[4:0] == OFF_IRQ_EN;
  assign sel_scr    = hi_zero && addr[4:0] == OFF_SCRATCH;
  assign sel_cnt    = hi_zero && addr[4:0] == OFF_CNT;

  assign mapped = sel_id | sel_ctrl | sel_status |
                  sel_ien | sel_scr | sel_cnt;

  assign err = (rd && wr) || !mapped ||
               (wr && (sel_id || sel_cnt));

  assign wr_ok = commit && wr && !err;

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_id:     rd_val = {ID_TAG, 12'h000, ecorevnum};
      sel_ctrl:   rd_val = ctrl_q;
      sel_status: rd_val = status_q;
      sel_ien:    rd_val = irq_en_q;
      sel_scr:    rd_val = scratch_q;
      sel_cnt:    rd_val = cnt_q;
      default:    rd_val = '0;
    endcase
  end

  assign clr = (wr_ok && sel_status) ?
               (wdata & lane_mask(b_strobe)) : '0;

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      ctrl_q    <= '0;
      status_q  <= '0;
      irq_en_q  <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (wr_ok && sel_ctrl)
        ctrl_q <= merge(ctrl_q, wdata, b_strobe);
      if (wr_ok && sel_ien)
        irq_en_q <= merge(irq_en_q, wdata, b_strobe);
      if (wr_ok && sel_scr)
        scratch_q <= merge(scratch_q, wdata, b_strobe);
      // Hardware set beats a same-cycle software clear.
      status_q <= (status_q & ~clr) | {31'b0, hw_event};
      cnt_q    <= cnt_q + {31'b0, ctrl_q[0]};
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      rdata     <= '0;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
    end else begin
      pready_r  <= commit;
      pslverr_r <= commit && err;
      if (commit && rd)
        rdata <= err ? '0 : rd_val;
    end
  end

  assign ctrl_out = ctrl_q;
  assign irq      = |(status_q & irq_en_q);

endmodule

// File: tb/tb_apb_reg_bank.sv
// Self-checking bench for apb_reg_bank: vector table,
// hand-written corner sequences and a randomized model run.
module tb_apb_reg_bank;
  import apb_reg_pkg::*;

  localparam int W = 1;

  logic        pclk = 1'b0;
  logic        prst_n = 1'b0;
  logic [11:0] addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [3:0]  b_strobe = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  ecorevnum = 4'h3;
  logic        hw_event = 1'b0;
  logic [31:0] rdata;
  logic        pready_r;
  logic        pslverr_r;
  logic [31:0] ctrl_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  apb_reg_bank #(
    .ADDR_WIDTH  (12),
    .DATA_WIDTH  (32),
    .WAIT_CYCLES (W)
  ) dut (
    .pclk      (pclk),
    .prst_n    (prst_n),
    .addr      (addr),
    .rd        (rd),
    .wr        (wr),
    .b_strobe  (b_strobe),
    .wdata     (wdata),
    .ecorevnum (ecorevnum),
    .hw_event  (hw_event),
    .rdata     (rdata),
    .pready_r  (pready_r),
    .pslverr_r (pslverr_r),
    .ctrl_out  (ctrl_out),
    .irq       (irq)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit          r;
    bit          w;
    logic [11:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic [31:0] m_ctrl, m_st, m_ien, m_scr, m_cnt;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic xfer(input bit r, input bit w,
                      input logic [11:0] a,
                      input logic [3:0] s,
                      input logic [31:0] d,
                      input bit hw,
                      output logic [31:0] rdv,
                      output bit errv);
    int lat;
    rd = r; wr = w; addr = a;
    b_strobe = s; wdata = d;
    hw_event = hw && (W == 0);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge pclk);
      if (pready_r) begin
        lat = n;
        break;
      end
      hw_event = hw && (n == W);
    end
    rdv = rdata;
    errv = pslverr_r;
    rd = 0; wr = 0; hw_event = 0;
    chk("latency", lat, W + 1);
    @(negedge pclk);
    chk("pready_low_after", {31'b0, pready_r}, 0);
    chk("pslverr_low_after", {31'b0, pslverr_r}, 0);
  endtask

  task automatic model(input bit r, input bit w,
                       input logic [11:0] a,
                       input logic [3:0] s,
                       input logic [31:0] d,
                       input bit hw,
                       output logic [31:0] er,
                       output bit ee);
    logic [31:0] m;
    logic [31:0] v;
    int idx;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    idx = int'(a) / 4;
    ee = (r && w) || (a % 4 != 0) || (a > 12'h014) ||
         (w && (idx == 0 || idx == 5));
    case (idx)
      0: v = {16'hA5B0, 12'h000, ecorevnum};
      1: v = m_ctrl;
      2: v = m_st;
      3: v = m_ien;
      4: v = m_scr;
      5: v = m_cnt;
      default: v = 0;
    endcase
    er = ee ? 32'h0 : v;
    if (w && !ee) begin
      case (idx)
        1: m_ctrl = (m_ctrl & ~m) | (d & m);
        2: m_st = m_st & ~(d & m);
        3: m_ien = (m_ien & ~m) | (d & m);
        4: m_scr = (m_scr & ~m) | (d & m);
        default: ;
      endcase
    end
    if (hw) m_st[0] = 1'b1;
  endtask

  initial begin
    logic [31:0] rv;
    logic [31:0] er;
    bit ev, ee;

    vecs.push_back('{1,0,12'h000,4'h0,0,32'hA5B00003,0});
    vecs.push_back('{0,1,12'h010,4'hF,32'hDEADBEEF,0,0});
    vecs.push_back('{0,1,12'h010,4'h3,32'h00001122,0,0});
    vecs.push_back('{1,0,12'h010,4'h0,0,32'hDEAD1122,0});
    vecs.push_back('{0,1,12'h010,4'h0,32'hFFFFFFFF,0,0});
    vecs.push_back('{1,0,12'h010,4'h0,0,32'hDEAD1122,0});
    vecs.push_back('{0,1,12'h018,4'hF,32'h55555555,0,1});
    vecs.push_back('{1,0,12'h006,4'h0,0,32'h0,1});
    vecs.push_back('{0,1,12'h014,4'hF,32'h12345678,0,1});
    vecs.push_back('{1,0,12'h014,4'h0,0,32'h0,0});
    vecs.push_back('{0,1,12'h000,4'hF,32'hFFFFFFFF,0,1});
    vecs.push_back('{1,0,12'h000,4'h0,0,32'hA5B00003,0});
    vecs.push_back('{1,1,12'h010,4'hF,32'h0,32'h0,1});
    vecs.push_back('{1,0,12'h010,4'h0,0,32'hDEAD1122,0});
    vecs.push_back('{1,0,12'h008,4'h0,0,32'h0,0});
    vecs.push_back('{0,1,12'h00C,4'hF,32'h1,0,0});
    vecs.push_back('{1,0,12'h00C,4'h0,0,32'h1,0});
    vecs.push_back('{1,0,12'h100,4'h0,0,32'h0,1});

    #12;
    chk("rst_rdata", rdata, 0);
    chk("rst_pready", {31'b0, pready_r}, 0);
    chk("rst_pslverr", {31'b0, pslverr_r}, 0);
    chk("rst_ctrl", ctrl_out, 0);
    chk("rst_irq", {31'b0, irq}, 0);
    @(negedge pclk);
    prst_n = 1'b1;
    @(negedge pclk);

    foreach (vecs[i]) begin
      xfer(vecs[i].r, vecs[i].w, vecs[i].a,
           vecs[i].s, vecs[i].d, 0, rv, ev);
      chk($sformatf("vec%0d_err", i),
          {31'b0, ev}, {31'b0, vecs[i].exp_err});
      if (vecs[i].r)
        chk($sformatf("vec%0d_rdata", i),
            rv, vecs[i].exp_rdata);
    end
    chk("ctrl_untouched", ctrl_out, 0);

    // hw_event raises irq; set beats same-cycle clear
    hw_event = 1;
    @(negedge pclk);
    hw_event = 0;
    chk("irq_set", {31'b0, irq}, 1);
    xfer(0, 1, 12'h008, 4'hF, 32'h1, 1, rv, ev);
    chk("irq_set_wins", {31'b0, irq}, 1);
    xfer(1, 0, 12'h008, 4'h0, 0, 0, rv, ev);
    chk("status_kept", rv, 1);
    xfer(0, 1, 12'h008, 4'hF, 32'h1, 0, rv, ev);
    chk("irq_cleared", {31'b0, irq}, 0);
    xfer(1, 0, 12'h008, 4'h0, 0, 0, rv, ev);
    chk("status_clr", rv, 0);

    // CNT wrap via backdoor
    force dut.cnt_q = 32'hFFFF_FFFE;
    @(posedge pclk);
    @(negedge pclk);
    release dut.cnt_q;
    chk("cnt_forced", dut.cnt_q, 32'hFFFF_FFFE);
    xfer(0, 1, 12'h004, 4'hF, 32'h1, 0, rv, ev);
    chk("ctrl_on", ctrl_out, 1);
    chk("cnt_ff", dut.cnt_q, 32'hFFFF_FFFF);
    @(posedge pclk); #1;
    chk("cnt_wrap", dut.cnt_q, 0);
    @(posedge pclk); #1;
    chk("cnt_after_wrap", dut.cnt_q, 1);
    @(negedge pclk);

    // reset in the middle of a SCRATCH write
    addr = 12'h010; wr = 1;
    b_strobe = 4'hF; wdata = 32'h12345678;
    @(posedge pclk); #1;
    chk("in_busy", {30'b0, dut.state_q}, {30'b0, ST_BUSY});
    prst_n = 0;
    #1;
    wr = 0;
    chk("abort_pready", {31'b0, pready_r}, 0);
    chk("abort_ctrl", ctrl_out, 0);
    @(negedge pclk);
    @(negedge pclk);
    prst_n = 1;
    @(negedge pclk);
    @(negedge pclk);
    chk("idle_after_rst", {30'b0, dut.state_q},
        {30'b0, ST_IDLE});
    xfer(1, 0, 12'h010, 4'h0, 0, 0, rv, ev);
    chk("scratch_aborted", rv, 0);

    // randomized run against the model
    m_ctrl = 0; m_st = 0; m_ien = 0;
    m_scr = 0; m_cnt = 0;
    for (int t = 0; t < 200; t++) begin
      logic [11:0] a;
      logic [3:0]  s;
      logic [31:0] d;
      bit r, w, hw;
      int k;
      k = $urandom_range(0, 9);
      r = (k <= 4);
      w = (k == 0) || (k >= 5);
      a = 12'($urandom_range(0, 8) * 4);
      if ($urandom_range(0, 7) == 0)
        a = a | 12'($urandom_range(1, 3));
      s = 4'($urandom);
      d = $urandom;
      if (a == 12'h004) d[0] = 1'b0;
      hw = ($urandom_range(0, 7) == 0);
      ecorevnum = 4'($urandom);
      model(r, w, a, s, d, hw, er, ee);
      xfer(r, w, a, s, d, hw, rv, ev);
      chk($sformatf("rnd%0d_err", t),
          {31'b0, ev}, {31'b0, ee});
      if (r)
        chk($sformatf("rnd%0d_rdata", t), rv, er);
      chk($sformatf("rnd%0d_ctrl", t), ctrl_out, m_ctrl);
      chk($sformatf("rnd%0d_irq", t),
          {31'b0, irq}, {31'b0, |(m_st & m_ien)});
      if ($urandom_range(0, 7) == 0) begin
        hw_event = 1;
        @(negedge pclk);
        hw_event = 0;
        m_st[0] = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
